bf16_mac_sequencer: RTL and testbench
=====================================

Name: bf16_mac_sequencer

Overview:
- Sequences the shared combinational BF16 fused multiply-add unit (result = A*B + C) through an N-element dot product: acc = c_init + sum(a_i * b_i).
- Pulls operand pairs from a valid/ready stream and drives the FMA A/B/C inputs from registers.
- Feeds each FMA result back as the next C operand and reports the final accumulator with sticky exception flags.
- Sits between the operand source (instruction/data memory front end) and the BF16 FMA datapath.

Parameters:
- LEN_W, 8, width of element-count input and internal counter.
- FMA_LAT, 0, extra settle/pipeline cycles the FMA result needs after its inputs change (0 = purely combinational).

Ports:
- clk_in  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a job; sampled only in IDLE.
- len  input  LEN_W  number of operand pairs; sampled with start.
- c_init  input  16  BF16 initial accumulator value; sampled with start.
- op_valid  input  1  operand pair available.
- op_a  input  16  BF16 multiplicand.
- op_b  input  16  BF16 multiplier.
- op_ready  output  1  sequencer accepts the pair this cycle.
- fma_a  output  16  to FMA A.
- fma_b  output  16  to FMA B.
- fma_c  output  16  to FMA C (the accumulator).
- fma_result  input  16  FMA result.
- fma_flags  input  6  {overflow, underflow, qNaN, sNaN, positive_inf, negative_inf} from FMA.
- busy  output  1  high in ISSUE/WAIT.
- done  output  1  one-cycle pulse when the job completes.
- acc_out  output  16  final accumulator; held until the next accepted start.
- flags_out  output  6  sticky OR of fma_flags over the job; held with acc_out.

Behaviour:
- Reset: state=IDLE; acc, op regs, fma_a/b/c, acc_out, flags_out, counters=0; op_ready=busy=done=0. Asynchronous: op_ready drops immediately; an aborted job produces no done.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, start=1, len>0: acc<=c_init, cnt<=len, sticky<=0 -> ISSUE.
- IDLE, start=1, len=0: acc_out<=c_init, flags_out<=0 -> DONE. done is high in the cycle after the start edge.
- ISSUE: op_ready=1; op_ready is 1 only in this state.
  - On op_valid&&op_ready: op_a/op_b captured into operand regs, wcnt<=FMA_LAT -> WAIT.
  - Otherwise stay in ISSUE. Gaps in op_valid are allowed without limit.
- fma_a/fma_b always equal the operand regs; fma_c always equals acc. Inputs are stable for the whole WAIT.
- WAIT: lasts FMA_LAT+1 cycles (wcnt counts down to 0). On the final WAIT edge:
  - acc<=fma_result, sticky|=fma_flags, cnt<=cnt-1.
  - If cnt==1 -> DONE, with acc_out<=fma_result and flags_out<=sticky|fma_flags. Else -> ISSUE.
- DONE: done=1 for exactly one cycle -> IDLE. acc_out/flags_out stay valid until the next accepted start.
- Throughput: one pair per FMA_LAT+2 cycles.
- Latency with op_valid held high: done rises after edge N*(FMA_LAT+2) following the start-sampling edge.
- start while busy or in DONE is ignored; no queueing.
- len, c_init and op_a/op_b are not required stable outside their sampling edges.
- fma_flags are ignored outside the final WAIT cycle.
- No abort on NaN: the job runs to completion and NaN propagates via the FMA.
- Counter arithmetic: len=2^LEN_W-1 is the maximum. cnt never wraps because it stops at 1 -> DONE.

Test Plan:
- FMA_LAT=0, start len=1 c_init=0x3F00, pair (0x3F80, 0x4000) -> op_ready high 1 cycle; done 2 cycles after start; acc_out=0x4020; flags_out=0.
- len=3 c_init=0x0000, pairs (0x3F80,0x3F80), (0x4000,0x3F80), (0x4040,0x3F80), op_valid dropped for 3 cycles between pairs 1 and 2 -> acc_out=0x40C0; done exactly once; cycle count extends by the 3 stall cycles.
- start len=0 c_init=0x4110 -> done in next cycle; acc_out=0x4110; flags_out=0; op_ready never asserted.
- len=2 c_init=0x0000, pairs (0x7F7F,0x4000), (0x3F80,0x3F80) -> overflow and positive_inf bits set in flags_out; acc_out=0x7F80.
- FMA_LAT=2 build, len=2 -> each WAIT lasts 3 cycles; done 8 cycles after start; fma_a/b/c stable throughout each WAIT.
- start pulsed mid-job -> ignored. rst asserted mid-WAIT -> all outputs 0 immediately, no done. New start after release -> correct fresh result.

Source files
------------

// File: rtl/bf16_mac_sequencer.sv
// Dot-product sequencer around a shared combinational BF16 FMA: acc = c_init + sum(a_i*b_i).
// Each FMA result is fed back as the next C operand; exception flags are accumulated stickily.
module bf16_mac_sequencer #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned FMA_LAT = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      c_init,
    input  logic             op_valid,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             op_ready,
    output logic [15:0]      fma_a,
    output logic [15:0]      fma_b,
    output logic [15:0]      fma_c,
    input  logic [15:0]      fma_result,
    input  logic [5:0]       fma_flags,
    output logic             busy,
    output logic             done,
    output logic [15:0]      acc_out,
    output logic [5:0]       flags_out
);

    localparam int unsigned WC_W = (FMA_LAT > 0) ? $clog2(FMA_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [WC_W-1:0]  r_wcnt;
    logic [15:0]      r_acc;
    logic [15:0]      r_op_a;
    logic [15:0]      r_op_b;
    logic [5:0]       r_sticky;
    logic [15:0]      r_acc_out;
    logic [5:0]       r_flags_out;
    logic             r_op_ready;
    logic             r_busy;
    logic             r_done;

    // FMA operands come straight from registers so they stay stable across WAIT
    assign fma_a     = r_op_a;
    assign fma_b     = r_op_b;
    assign fma_c     = r_acc;
    assign op_ready  = r_op_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign acc_out   = r_acc_out;
    assign flags_out = r_flags_out;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wcnt      <= '0;
            r_acc       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sticky    <= '0;
            r_acc_out   <= '0;
            r_flags_out <= '0;
            r_op_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_acc      <= c_init;
                            r_cnt      <= len;
                            r_sticky   <= '0;
                            r_op_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_acc_out   <= c_init;
                            r_flags_out <= '0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_valid) begin
                        r_op_a     <= op_a;
                        r_op_b     <= op_b;
                        r_wcnt     <= WC_W'(FMA_LAT);
                        r_op_ready <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - WC_W'(1);
                    end else begin
                        // result is settled: fold into the accumulator
                        r_acc    <= fma_result;
                        r_sticky <= r_sticky | fma_flags;
                        r_cnt    <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_acc_out   <= fma_result;
                            r_flags_out <= r_sticky | fma_flags;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_op_ready <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_mac_sequencer.sv
// Scoreboard bench for bf16_mac_sequencer: a combinational-latency build and an FMA_LAT=2 build,
// each driven by a table-based BF16 FMA model with hand-computed results.
module tb_bf16_mac_sequencer;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst;
    logic        start [2];
    logic [7:0]  len [2];
    logic [15:0] c_init [2];
    logic        op_valid [2];
    logic [15:0] op_a [2];
    logic [15:0] op_b [2];
    logic        op_ready [2];
    logic [15:0] fma_a [2];
    logic [15:0] fma_b [2];
    logic [15:0] fma_c [2];
    logic [15:0] fma_result [2];
    logic [5:0]  fma_flags [2];
    logic        busy [2];
    logic        done [2];
    logic [15:0] acc_out [2];
    logic [5:0]  flags_out [2];

    bf16_mac_sequencer #(.LEN_W(8), .FMA_LAT(0)) u_lat0 (
        .clk_in(clk_in), .rst(rst), .start(start[0]), .len(len[0]), .c_init(c_init[0]),
        .op_valid(op_valid[0]), .op_a(op_a[0]), .op_b(op_b[0]), .op_ready(op_ready[0]),
        .fma_a(fma_a[0]), .fma_b(fma_b[0]), .fma_c(fma_c[0]),
        .fma_result(fma_result[0]), .fma_flags(fma_flags[0]),
        .busy(busy[0]), .done(done[0]), .acc_out(acc_out[0]), .flags_out(flags_out[0])
    );

    bf16_mac_sequencer #(.LEN_W(8), .FMA_LAT(2)) u_lat2 (
        .clk_in(clk_in), .rst(rst), .start(start[1]), .len(len[1]), .c_init(c_init[1]),
        .op_valid(op_valid[1]), .op_a(op_a[1]), .op_b(op_b[1]), .op_ready(op_ready[1]),
        .fma_a(fma_a[1]), .fma_b(fma_b[1]), .fma_c(fma_c[1]),
        .fma_result(fma_result[1]), .fma_flags(fma_flags[1]),
        .busy(busy[1]), .done(done[1]), .acc_out(acc_out[1]), .flags_out(flags_out[1])
    );

    // Known A*B+C results; anything else returns qNaN with the qNaN flag so stray sampling shows up
    function automatic logic [21:0] fma_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c);
        logic [47:0] k;
        k = {a, b, c};
        case (k)
            48'h0000_0000_0000: return {6'b000000, 16'h0000};
            48'h3F80_4000_3F00: return {6'b000000, 16'h4020};
            48'h3F80_3F80_0000: return {6'b000000, 16'h3F80};
            48'h4000_3F80_3F80: return {6'b000000, 16'h4040};
            48'h4040_3F80_4040: return {6'b000000, 16'h40C0};
            48'h7F7F_4000_0000: return {6'b100010, 16'h7F80};
            48'h3F80_3F80_7F80: return {6'b000010, 16'h7F80};
            48'h4000_4000_3F00: return {6'b000000, 16'h4090};
            48'h4000_4000_4020: return {6'b000000, 16'h40D0};
            default:            return {6'b001000, 16'h7FC0};
        endcase
    endfunction

    always_comb {fma_flags[0], fma_result[0]} = fma_model(fma_a[0], fma_b[0], fma_c[0]);

    // The LAT=2 model yields garbage until its inputs have been stable for two cycles
    logic [47:0] prev1 = '0;
    int          age1 = 0;
    logic [21:0] w_res1;
    always @(negedge clk_in) begin
        if ({fma_a[1], fma_b[1], fma_c[1]} != prev1) age1 <= 0;
        else if (age1 < 10) age1 <= age1 + 1;
        prev1 <= {fma_a[1], fma_b[1], fma_c[1]};
    end
    always_comb begin
        w_res1 = fma_model(fma_a[1], fma_b[1], fma_c[1]);
        if (age1 < 2) w_res1 = {6'b111111, 16'hDEAD};
        {fma_flags[1], fma_result[1]} = w_res1;
    end

    typedef struct {
        logic [15:0] acc;
        logic [5:0]  flg;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t_start [2];
    int   rdy_cnt [2];
    int   done_cnt [2];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   sz;
        if (op_ready[d]) rdy_cnt[d]++;
        if (done[d]) begin
            done_cnt[d]++;
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                chk($sformatf("unexpected_done_dut%0d", d), 32'(done[d]), 32'd0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("acc_out_dut%0d", d), 32'(acc_out[d]), 32'(e.acc));
                chk($sformatf("flags_out_dut%0d", d), 32'(flags_out[d]), 32'(e.flg));
                chk($sformatf("done_latency_dut%0d", d), 32'(cyc - t_start[d]), 32'(e.lat));
            end
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    task automatic start_job(input int d, input logic [7:0] n, input logic [15:0] c,
                             input logic [15:0] ea, input logic [5:0] ef, input int elat,
                             input bit push);
        exp_t e;
        @(negedge clk_in);
        start[d] = 1'b1; len[d] = n; c_init[d] = c;
        @(posedge clk_in); #1;
        start[d] = 1'b0; len[d] = 8'hA5; c_init[d] = 16'h1234;
        t_start[d] = cyc;
        e.acc = ea; e.flg = ef; e.lat = elat;
        if (push) begin
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic send_pair(input int d, input logic [15:0] a, input logic [15:0] b,
                             input int gap);
        int t;
        t = 0;
        @(negedge clk_in);
        while (!op_ready[d] && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 100) chk("op_ready_timeout", 32'(op_ready[d]), 32'd1);
        repeat (gap) @(negedge clk_in);
        op_valid[d] = 1'b1; op_a[d] = a; op_b[d] = b;
        @(posedge clk_in); #1;
        op_valid[d] = 1'b0; op_a[d] = 16'hBAD0; op_b[d] = 16'hBAD1;
    endtask

    task automatic wait_done(input int d);
        int t;
        t = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && t < 200) begin
            @(negedge clk_in);
            t++;
        end
        chk($sformatf("job_complete_dut%0d", d), 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
        repeat (2) @(negedge clk_in);
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_op_ready"}, 32'(op_ready[d]), 32'd0);
        chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
        chk({tag, "_done"}, 32'(done[d]), 32'd0);
        chk({tag, "_acc_out"}, 32'(acc_out[d]), 32'd0);
        chk({tag, "_flags_out"}, 32'(flags_out[d]), 32'd0);
        chk({tag, "_fma_abc"}, 32'({fma_a[d], fma_b[d]} | 32'(fma_c[d])), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d limit=20000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; len[i] = '0; c_init[i] = '0;
            op_valid[i] = 1'b0; op_a[i] = '0; op_b[i] = '0;
            t_start[i] = 0; rdy_cnt[i] = 0; done_cnt[i] = 0;
        end
        repeat (3) @(negedge clk_in);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst = 1'b0;

        // single pair, combinational FMA
        r0 = rdy_cnt[0];
        start_job(0, 8'd1, 16'h3F00, 16'h4020, 6'b000000, 2, 1'b1);
        send_pair(0, 16'h3F80, 16'h4000, 0);
        wait_done(0);
        chk("t1_ready_cycles", 32'(rdy_cnt[0] - r0), 32'd1);

        // three pairs with a 3-cycle valid gap before the second pair
        d0 = done_cnt[0];
        start_job(0, 8'd3, 16'h0000, 16'h40C0, 6'b000000, 9, 1'b1);
        send_pair(0, 16'h3F80, 16'h3F80, 0);
        send_pair(0, 16'h4000, 16'h3F80, 3);
        send_pair(0, 16'h4040, 16'h3F80, 0);
        wait_done(0);
        chk("t2_done_once", 32'(done_cnt[0] - d0), 32'd1);

        // zero-length job
        r0 = rdy_cnt[0];
        start_job(0, 8'd0, 16'h4110, 16'h4110, 6'b000000, 0, 1'b1);
        wait_done(0);
        chk("t3_ready_cycles", 32'(rdy_cnt[0] - r0), 32'd0);

        // overflow to +inf, flags stay sticky through the second pair
        start_job(0, 8'd2, 16'h0000, 16'h7F80, 6'b100010, 4, 1'b1);
        send_pair(0, 16'h7F7F, 16'h4000, 0);
        send_pair(0, 16'h3F80, 16'h3F80, 0);
        wait_done(0);

        // start held high during WAIT and ISSUE of a running job is ignored
        d0 = done_cnt[0];
        start_job(0, 8'd2, 16'h0000, 16'h4040, 6'b000000, 4, 1'b1);
        send_pair(0, 16'h3F80, 16'h3F80, 0);
        start[0] = 1'b1; len[0] = 8'd1; c_init[0] = 16'h4110;
        send_pair(0, 16'h4000, 16'h3F80, 0);
        start[0] = 1'b0;
        wait_done(0);
        chk("t5_done_once", 32'(done_cnt[0] - d0), 32'd1);

        // asynchronous reset in the middle of WAIT
        d0 = done_cnt[0];
        start_job(0, 8'd1, 16'h3F00, 16'h0000, 6'b000000, 0, 1'b0);
        send_pair(0, 16'h3F80, 16'h4000, 0);
        #1 rst = 1'b1;
        #1 chk_zero(0, "midreset");
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("t6_no_done", 32'(done_cnt[0] - d0), 32'd0);

        // fresh job after reset release
        start_job(0, 8'd1, 16'h3F00, 16'h4090, 6'b000000, 2, 1'b1);
        send_pair(0, 16'h4000, 16'h4000, 0);
        wait_done(0);

        // FMA_LAT=2 build: 3-cycle WAIT, done 8 cycles after start, operands stable in WAIT
        start_job(1, 8'd2, 16'h3F00, 16'h40D0, 6'b000000, 8, 1'b1);
        send_pair(1, 16'h3F80, 16'h4000, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk($sformatf("lat2_wait_ops_%0d", k), {fma_a[1], fma_b[1]}, 32'h3F80_4000);
            chk($sformatf("lat2_wait_acc_%0d", k), 32'(fma_c[1]), 32'h3F00);
        end
        send_pair(1, 16'h4000, 16'h4000, 0);
        wait_done(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
